// File: rtl/cycle_term_gen.sv
// Register-cycle termination generator: per-channel wait states, then REG_DSK_ or external termination.
// Optional bus-error timeout enabled by defining TERM_TIMEOUT_EN.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  IDLE     | no cycle owned; latch lowest active chip select on AS_ low
//  COUNT    | burning the latched channel's wait states
//  TERM     | REG_DSK_ asserted, waiting for AS_ to rise
//  WAIT_EXT | target terminates itself, waiting for AS_ to rise
//  HOLD     | timed out, BERR_ asserted until AS_ rises
module cycle_term_gen #(
  parameter int                      NUM_CH      = 4,
  parameter int                      CNT_W       = 4,
  parameter logic [NUM_CH*CNT_W-1:0] WAIT_STATES = {NUM_CH{CNT_W'(4)}},
  parameter int                      TIMEOUT     = 255
) (
  input  logic              nCPUCLK,
  input  logic              RST,
  input  logic              AS_,
  input  logic [NUM_CH-1:0] SEL_,
  input  logic [NUM_CH-1:0] EXT_TERM,
  output logic              REG_DSK_,
  output logic              BERR_,
  output logic [NUM_CH-1:0] CH_ACTIVE,
  output logic              BUSY
);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("cycle_term_gen: NUM_CH must be 1..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("cycle_term_gen: TIMEOUT must be 1..255");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COUNT    = 3'd1,
    TERM     = 3'd2,
    WAIT_EXT = 3'd3,
    HOLD     = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [NUM_CH-1:0] ch_n;
  logic [NUM_CH-1:0] sel_oh;
  logic [CNT_W-1:0]  sel_ws;
  logic              sel_any;
  logic              ext_sel;
  logic              abort;
  logic              tmo_hit;

  // Scan from the top down so the lowest-index low select wins.
  always_comb begin
    sel_oh = '0;
    sel_ws = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!SEL_[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_ws    = WAIT_STATES[i*CNT_W +: CNT_W];
      end
    end
  end

  assign sel_any = ~&SEL_;
  assign ext_sel = |(EXT_TERM & CH_ACTIVE);
  assign abort   = (state != IDLE) && AS_;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ch_n    = CH_ACTIVE;
    if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      ch_n    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!AS_ && sel_any) begin
            state_n = COUNT;
            cnt_n   = sel_ws;
            ch_n    = sel_oh;
          end
        end
        COUNT: begin
          if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
            if (tmo_hit) state_n = HOLD;
          end else if (!ext_sel) begin
            // Internal termination beats a timeout landing on the same edge.
            state_n = TERM;
          end else begin
            state_n = tmo_hit ? HOLD : WAIT_EXT;
          end
        end
        WAIT_EXT: begin
          if (tmo_hit) state_n = HOLD;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge nCPUCLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      CH_ACTIVE <= '0;
      REG_DSK_  <= 1'b1;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      CH_ACTIVE <= ch_n;
      REG_DSK_  <= (state_n != TERM);
      BUSY      <= (state_n != IDLE);
    end
  end

`ifdef TERM_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  logic [7:0] tmo, tmo_inc;
  logic       latch, counting;

  assign latch    = (state == IDLE) && !AS_ && sel_any;
  assign counting = ((state == COUNT) || (state == WAIT_EXT)) && !AS_;
  assign tmo_inc  = (tmo == TMO_LIM) ? tmo : tmo + 8'd1;
  assign tmo_hit  = counting && (tmo_inc == TMO_LIM);

  always_ff @(posedge nCPUCLK) begin
    if (RST) begin
      tmo   <= '0;
      BERR_ <= 1'b1;
    end else begin
      if (latch || abort) tmo <= '0;
      else if (counting)  tmo <= tmo_inc;
      BERR_ <= (state_n != HOLD);
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign BERR_   = 1'b1;
`endif

endmodule

// File: tb/tb_cycle_term_gen.sv
// Bench for cycle_term_gen: directed vector table plus randomized run against an age-based model.
module tb_cycle_term_gen;

  localparam int NCH = 4;
  localparam int CW  = 5;
  localparam int TMO = 20;
`ifdef TERM_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic           nCPUCLK = 1'b0;
  logic           RST = 1'b1;
  logic           AS_ = 1'b1;
  logic [NCH-1:0] SEL_ = '1;
  logic [NCH-1:0] EXT_TERM = '0;
  logic           REG_DSK_, BERR_, BUSY;
  logic [NCH-1:0] CH_ACTIVE;

  int ws[NCH] = '{3, 0, 4, 19};

  cycle_term_gen #(
    .NUM_CH     (NCH),
    .CNT_W      (CW),
    .WAIT_STATES({5'd19, 5'd4, 5'd0, 5'd3}),
    .TIMEOUT    (TMO)
  ) dut (
    .nCPUCLK  (nCPUCLK),
    .RST      (RST),
    .AS_      (AS_),
    .SEL_     (SEL_),
    .EXT_TERM (EXT_TERM),
    .REG_DSK_ (REG_DSK_),
    .BERR_    (BERR_),
    .CH_ACTIVE(CH_ACTIVE),
    .BUSY     (BUSY)
  );

  always #5 nCPUCLK = ~nCPUCLK;

  typedef struct {
    logic           rst;
    logic           as_n;
    logic [NCH-1:0] sel;
    logic [NCH-1:0] ext;
    logic           dsk;
    logic           berr;
    logic [NCH-1:0] ch;
    logic           busy;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic v(input logic rst, input logic as_n, input logic [NCH-1:0] sel,
                   input logic [NCH-1:0] ext, input logic dsk, input logic berr,
                   input logic [NCH-1:0] ch, input logic busy);
    vec_t t;
    t.rst = rst; t.as_n = as_n; t.sel = sel; t.ext = ext;
    t.dsk = dsk; t.berr = berr; t.ch = ch; t.busy = busy;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [NCH-1:0] act,
                     input logic [NCH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic drive_edge(input logic rst, input logic as_n, input logic [NCH-1:0] sel,
                            input logic [NCH-1:0] ext);
    RST = rst; AS_ = as_n; SEL_ = sel; EXT_TERM = ext;
    @(posedge nCPUCLK);
    #1;
  endtask

  task automatic fill_table();
    // reset, including reset overriding a live strobe
    v(1, 1, 4'hF, 4'h0, 1, 1, 4'h0, 0);
    v(1, 0, 4'h0, 4'h0, 1, 1, 4'h0, 0);
    // strobe without any select stays idle
    v(0, 0, 4'hF, 4'h0, 1, 1, 4'h0, 0);
    v(0, 0, 4'hF, 4'hF, 1, 1, 4'h0, 0);
    // channel 2, W=4; later select/ext noise on other channels ignored
    v(0, 0, 4'b1011, 4'h0, 1, 1, 4'b0100, 1);
    for (int e = 1; e <= 4; e++) v(0, 0, 4'b0000, 4'b1011, 1, 1, 4'b0100, 1);
    v(0, 0, 4'b1110, 4'b1011, 0, 1, 4'b0100, 1);
    v(0, 0, 4'hF,    4'b0100, 0, 1, 4'b0100, 1);
    v(0, 1, 4'hF,    4'h0,    1, 1, 4'h0,    0);
    // all selects low -> channel 0
    v(0, 0, 4'b0000, 4'h0, 1, 1, 4'b0001, 1);
    v(0, 1, 4'hF,    4'h0, 1, 1, 4'h0,    0);
    // channel 1, W=0 -> strobe after edge 1
    v(0, 0, 4'b1101, 4'h0, 1, 1, 4'b0010, 1);
    v(0, 0, 4'b1101, 4'h0, 0, 1, 4'b0010, 1);
    v(0, 1, 4'hF,    4'h0, 1, 1, 4'h0,    0);
    // CPU abort after edge 2, then a clean cycle
    v(0, 0, 4'b1011, 4'h0, 1, 1, 4'b0100, 1);
    v(0, 0, 4'b1011, 4'h0, 1, 1, 4'b0100, 1);
    v(0, 0, 4'b1011, 4'h0, 1, 1, 4'b0100, 1);
    v(0, 1, 4'b1011, 4'h0, 1, 1, 4'h0,    0);
    v(0, 0, 4'b1011, 4'h0, 1, 1, 4'b0100, 1);
    for (int e = 1; e <= 4; e++) v(0, 0, 4'b1011, 4'h0, 1, 1, 4'b0100, 1);
    v(0, 0, 4'b1011, 4'h0, 0, 1, 4'b0100, 1);
    v(0, 1, 4'hF,    4'h0, 1, 1, 4'h0,    0);
    // reset during TERM with AS_ low, then relatch
    v(0, 0, 4'b1101, 4'h0, 1, 1, 4'b0010, 1);
    v(0, 0, 4'b1101, 4'h0, 0, 1, 4'b0010, 1);
    v(1, 0, 4'b1101, 4'h0, 1, 1, 4'h0,    0);
    v(0, 0, 4'b1101, 4'h0, 1, 1, 4'b0010, 1);
    v(0, 0, 4'b1101, 4'h0, 0, 1, 4'b0010, 1);
    v(0, 1, 4'hF,    4'h0, 1, 1, 4'h0,    0);
    // externally terminated channel 2: bus error after edge 20 only with timeout
    v(0, 0, 4'b1011, 4'b0100, 1, 1, 4'b0100, 1);
    for (int e = 1; e <= 24; e++)
      v(0, 0, 4'b1011, 4'b0100, 1, !(TMO_ON && e >= TMO), 4'b0100, 1);
    v(0, 1, 4'hF, 4'b0100, 1, 1, 4'h0, 0);
    // channel 3, W=19: termination and timeout coincide on edge 20
    v(0, 0, 4'b0111, 4'h0, 1, 1, 4'b1000, 1);
    for (int e = 1; e <= 24; e++)
      v(0, 0, 4'b0111, 4'h0, (e >= 20) ? 1'b0 : 1'b1, 1, 4'b1000, 1);
    v(0, 1, 4'hF, 4'h0, 1, 1, 4'h0, 0);
  endtask

  // Model state: a cycle is described by its owner channel and its age in edges.
  bit m_active = 0;
  int m_ch     = 0;
  int m_age    = 0;
  bit m_term   = 0;

  task automatic model_edge(input logic rst, input logic as_n, input logic [NCH-1:0] sel,
                            input logic [NCH-1:0] ext);
    if (rst) begin
      m_active = 0;
    end else if (m_active) begin
      if (as_n) m_active = 0;
      else begin
        if (m_age < 10000) m_age++;
        if (m_age == ws[m_ch] + 1) m_term = !ext[m_ch];
      end
    end else if (!as_n && sel != '1) begin
      m_active = 1;
      m_age    = 0;
      m_term   = 0;
      m_ch     = 0;
      for (int i = NCH - 1; i >= 0; i--) if (!sel[i]) m_ch = i;
    end
  endtask

  initial begin
    fill_table();
    foreach (vq[i]) begin
      drive_edge(vq[i].rst, vq[i].as_n, vq[i].sel, vq[i].ext);
      chk("tbl_dsk",  i, NCH'(REG_DSK_), NCH'(vq[i].dsk));
      chk("tbl_berr", i, NCH'(BERR_),    NCH'(vq[i].berr));
      chk("tbl_ch",   i, CH_ACTIVE,      vq[i].ch);
      chk("tbl_busy", i, NCH'(BUSY),     NCH'(vq[i].busy));
    end

    for (int c = 0; c < 1500; c++) begin
      logic           r, a;
      logic [NCH-1:0] s, x, exp_ch;
      bit             tfire, dlow;
      int             w;
      r = ($urandom_range(0, 99) < 2);
      a = ($urandom_range(0, 99) < 7);
      s = NCH'($urandom);
      x = NCH'($urandom);
      model_edge(r, a, s, x);
      drive_edge(r, a, s, x);
      w      = ws[m_ch];
      exp_ch = m_active ? NCH'(1) << m_ch : '0;
      tfire  = TMO_ON && m_active && m_age >= TMO && !(m_term && w + 1 <= TMO);
      dlow   = m_active && m_term && m_age >= w + 1 && !(TMO_ON && TMO < w + 1);
      chk("rnd_dsk",  c, NCH'(REG_DSK_), NCH'(!dlow));
      chk("rnd_berr", c, NCH'(BERR_),    NCH'(!tfire));
      chk("rnd_ch",   c, CH_ACTIVE,      exp_ch);
      chk("rnd_busy", c, NCH'(BUSY),     NCH'(m_active));
      chk("rnd_excl", c, NCH'(REG_DSK_ | BERR_), NCH'(1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cycle_term_gen.md
CYCLE_TERM_GEN -- requirements
Module: cycle_term_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of register chip-select channels (1..8).
REQ-002 Parameter CNT_W, default 4: wait-state counter width in bits.
REQ-003 Parameter WAIT_STATES, width NUM_CH*CNT_W, default all fields 4: packed per-channel wait-state counts; channel n uses bits [n*CNT_W +: CNT_W].
REQ-004 Parameter TIMEOUT, default 255: 8-bit bus-error timeout in clocks; used only when TERM_TIMEOUT_EN is defined.
REQ-005 nCPUCLK  input  1  the single clock; all state changes on its rising edge.
REQ-006 RST  input  1  reset; synchronous and active-high.
REQ-007 AS_  input  1  CPU address strobe, active-low.
REQ-008 SEL_  input  NUM_CH  per-channel chip selects, active-low.
REQ-009 EXT_TERM  input  NUM_CH  per-channel flag; 1 = the target device terminates the cycle itself and no internal termination is given.
REQ-010 REG_DSK_  output  1  registered termination strobe, active-low.
REQ-011 BERR_  output  1  registered bus error, active-low.
REQ-012 CH_ACTIVE  output  NUM_CH  registered one-hot channel owning the current cycle; all zero when idle.
REQ-013 BUSY  output  1  registered; 1 whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, COUNT, TERM, WAIT_EXT and HOLD.
REQ-015 IDLE: on an edge with AS_=0 and any SEL_ bit low, latch the lowest-index low SEL_ bit into CH_ACTIVE, load the counter with that channel's WAIT_STATES field, and go to COUNT.
REQ-016 IDLE with AS_=0 and all SEL_ high SHALL remain in IDLE with no outputs asserted.
REQ-017 COUNT with counter not equal to 0: decrement by 1 on each edge; the counter SHALL NOT wrap below 0.
REQ-018 COUNT with counter equal to 0: if EXT_TERM of the latched channel is 0, go to TERM and drive REG_DSK_=0 on the same edge; otherwise go to WAIT_EXT.
REQ-019 REG_DSK_ SHALL fall exactly W+1 edges after the latch edge, where W is the channel's wait-state field; W=0 gives 1 edge.
REQ-020 TERM: REG_DSK_ SHALL remain 0 until AS_ is sampled high.
REQ-021 WAIT_EXT: REG_DSK_ SHALL remain 1; the block SHALL wait for AS_ to be sampled high.
REQ-022 HOLD (entered only on timeout): BERR_ SHALL remain 0 until AS_ is sampled high.
REQ-023 AS_ sampled high in any non-IDLE state SHALL go to IDLE on that edge, drive REG_DSK_=1 and BERR_=1, clear CH_ACTIVE, and clear the counters; this covers CPU aborts mid-count.
REQ-024 Changes on SEL_ and on EXT_TERM of non-latched channels SHALL be ignored after the latch edge.
REQ-025 A new cycle SHALL require at least one edge with AS_ sampled high in between; the IDLE-return edge SHALL NOT also latch a new cycle.
REQ-026 REG_DSK_ and BERR_ SHALL never both be 0.

Reset
REQ-027 RST=1 on an edge SHALL force IDLE with REG_DSK_=1, BERR_=1, CH_ACTIVE=0, BUSY=0, and all counters 0, overriding every other input.
REQ-028 Deasserting RST mid-cycle with AS_ still low SHALL start a new latch from IDLE on the next qualifying edge.

Configuration
REQ-029 With the macro TERM_TIMEOUT_EN defined, an 8-bit timeout counter SHALL clear on the latch edge and increment on each edge in COUNT or WAIT_EXT, saturating at TIMEOUT.
REQ-030 With TERM_TIMEOUT_EN defined, on the edge where the timeout counter equals TIMEOUT, the block SHALL go to HOLD and drive BERR_=0; a COUNT-to-TERM transition on the same edge SHALL take priority over the timeout.
REQ-031 Without TERM_TIMEOUT_EN, there SHALL be no timeout counter, BERR_ SHALL be constant 1, and HOLD SHALL be unreachable.

Verification
REQ-032 Defaults, SEL_=4'b1011, AS_ low at edge 0, EXT_TERM=0 -> CH_ACTIVE=4'b0100, BUSY=1 after edge 0, REG_DSK_=0 after edge 5, REG_DSK_=1 on the first edge with AS_ high.
REQ-033 SEL_=4'b0000 -> CH_ACTIVE=4'b0001; channel 1 with WAIT_STATES field 0 -> REG_DSK_=0 after edge 1.
REQ-034 AS_ raised after edge 2 of a W=4 cycle -> REG_DSK_ never falls, IDLE reached on that edge, no spurious termination on the next cycle.
REQ-035 EXT_TERM[2]=1, TERM_TIMEOUT_EN with TIMEOUT=20 -> REG_DSK_ stays 1, BERR_=0 after edge 20, BERR_=1 when AS_ is sampled high; without the macro, BERR_ stays 1 indefinitely.
REQ-036 RST=1 asserted during TERM -> REG_DSK_=1, CH_ACTIVE=0, BUSY=0 on that edge even though AS_ is still low.
